// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one word-wide memory port between instruction fetch (I)
//            and data refill/write-back (D). D has priority; I is forced
//            through after STARVE_LIMIT consecutive D grants while it waits.
// Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write_en,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        grant_owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter value on the last BUSY cycle is zero, so load latency-1.
    localparam logic [3:0] LAT_LAST   = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  streak_q, streak_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        grant_to_d;

    // State and transaction registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            streak_q  <= '0;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            streak_q  <= streak_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Arbitration, latency countdown and read-data capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        grant_to_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // D wins unless I has already waited through a full streak.
                    grant_to_d = d_req && !(i_req && (streak_q == STREAK_MAX));
                    owner_d    = grant_to_d;
                    addr_d     = (grant_to_d ? d_addr : i_addr) & ~32'h3;
                    we_d       = grant_to_d & d_we;
                    wdata_d    = d_wdata;
                    if (grant_to_d && i_req) begin
                        streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX
                                                             : streak_q + 4'd1;
                    end else begin
                        streak_d = '0;
                    end
                    cnt_d   = LAT_LAST;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        if (owner_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            i_rdata_d = mem_rdata;
                        end
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // Requester still holds req this cycle, so always pass through IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_write_en = (state_q == BUSY) && (cnt_q == 4'd0) && we_q;
    assign i_ack        = (state_q == DONE) && !owner_q;
    assign d_ack        = (state_q == DONE) && owner_q;
    assign i_rdata      = i_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign busy         = (state_q != IDLE);
    assign grant_owner  = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed stimulus for mem_port_arbiter with a transaction-phase
//            reference model and hand-computed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int L  = 2;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write_en;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        grant_owner;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst_b(rst_b),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_en(mem_write_en),
        .mem_rdata(mem_rdata), .busy(busy), .grant_owner(grant_owner)
    );

    // Memory seen by the DUT: combinational read, write on the clock edge.
    logic [31:0] memarr [0:255];
    assign mem_rdata = memarr[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write_en) memarr[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each transaction is tracked by its phase since grant.
    // Phase 1..L is the memory access, L+1 is the ack cycle, then idle.
    bit          m_act = 1'b0;
    int          m_ph = 0;
    bit          m_own = 1'b0;
    bit          m_we = 1'b0;
    bit          m_gd = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_ir = '0, m_dr = '0;
    int          m_streak = 0;
    logic [31:0] m_mem [0:255];

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_b) begin
                m_act = 0; m_ph = 0; m_own = 0; m_we = 0; m_streak = 0;
                m_addr = '0; m_wdata = '0; m_ir = '0; m_dr = '0;
            end else if (m_act) begin
                if (m_ph == L) begin
                    if (m_we) m_mem[m_addr[9:2]] = m_wdata;
                    else if (m_own) m_dr = m_mem[m_addr[9:2]];
                    else m_ir = m_mem[m_addr[9:2]];
                end
                if (m_ph == L + 1) m_act = 0;
                else m_ph++;
            end else if (i_req || d_req) begin
                m_gd = d_req && !(i_req && m_streak == SL);
                m_own = m_gd;
                m_addr = (m_gd ? d_addr : i_addr) & ~32'h3;
                m_we = m_gd && d_we;
                m_wdata = d_wdata;
                if (m_gd && i_req) m_streak = (m_streak < SL) ? m_streak + 1 : SL;
                else m_streak = 0;
                m_act = 1;
                m_ph = 1;
            end
        end
    end

    // Per-cycle comparison against the model, plus grant-order log.
    bit   cmp_en = 1'b0;
    bit   prev_busy = 1'b0;
    logic gq [$];
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("busy", busy, m_act);
                chk("mem_write_en", mem_write_en, m_act && m_ph == L && m_we);
                chk("i_ack", i_ack, m_act && m_ph == L + 1 && !m_own);
                chk("d_ack", d_ack, m_act && m_ph == L + 1 && m_own);
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wdata", mem_wdata, m_wdata);
                chk("grant_owner", grant_owner, m_own);
                chk("i_rdata", i_rdata, m_ir);
                chk("d_rdata", d_rdata, m_dr);
                chk("ack_exclusive", i_ack & d_ack, 1'b0);
                if (busy && !prev_busy) gq.push_back(grant_owner);
            end
            prev_busy = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        chk("wait_idle_bound", busy, 1'b0);
        step();
    endtask

    int ic, dc;

    initial begin
        for (int k = 0; k < 256; k++) begin
            memarr[k] = 32'hC0DE_0000 | k;
            m_mem[k]  = 32'hC0DE_0000 | k;
        end
        memarr[8'h41] = 32'hDEAD_BEEF;
        m_mem[8'h41]  = 32'hDEAD_BEEF;

        // Reset state
        step(); step();
        cmp_en = 1'b1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_owner", grant_owner, 1'b0);
        rst_b = 1'b1;
        step();

        // 1: I read of 0x106 -> word 0x104
        i_addr = 32'h0000_0106; i_req = 1'b1;
        step(); chk("t1_addr_c1", mem_addr, 32'h104);
        step(); chk("t1_addr_c2", mem_addr, 32'h104);
        step();
        chk("t1_iack_c3", i_ack, 1'b1);
        chk("t1_rdata", i_rdata, 32'hDEAD_BEEF);
        chk("t1_dack", d_ack, 1'b0);
        i_req = 1'b0;
        wait_idle();

        // 2: D write then read back
        d_addr = 32'h40; d_wdata = 32'h1122_3344; d_we = 1'b1; d_req = 1'b1;
        step(); chk("t2_we_c1", mem_write_en, 1'b0);
        step();
        chk("t2_we_c2", mem_write_en, 1'b1);
        chk("t2_addr_c2", mem_addr, 32'h40);
        chk("t2_wdata_c2", mem_wdata, 32'h1122_3344);
        step();
        chk("t2_dack_c3", d_ack, 1'b1);
        chk("t2_we_c3", mem_write_en, 1'b0);
        d_req = 1'b0;
        wait_idle();
        d_we = 1'b0; d_req = 1'b1;
        step(); step(); step();
        chk("t2_rd_dack", d_ack, 1'b1);
        chk("t2_rd_data", d_rdata, 32'h1122_3344);
        d_req = 1'b0;
        wait_idle();

        // 3: simultaneous requests; D first, I after the mandatory idle
        ic = -1; dc = -1;
        i_addr = 32'h0000_0104; d_addr = 32'h40; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 5) chk("t3_owner_c5", grant_owner, 1'b0);
            if (i_ack && ic < 0) begin ic = c; i_req = 1'b0; end
            if (d_ack && dc < 0) begin dc = c; d_req = 1'b0; end
        end
        chk("t3_dack_cycle", dc, 3);
        chk("t3_iack_cycle", ic, 7);
        wait_idle();

        // 4: starvation guard with both requesters always asking
        gq.delete();
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        for (int c = 0; c < 42; c++) step();
        i_req = 1'b0; d_req = 1'b0;
        wait_idle();
        chk("t4_grant_count", (gq.size() >= 10) ? 1 : 0, 1);
        for (int g = 0; g < 10; g++) begin
            if (g < gq.size())
                chk($sformatf("t4_grant%0d", g), gq[g], (g == 4 || g == 9) ? 1'b0 : 1'b1);
        end

        // 5: reset during the first BUSY cycle of a write
        d_addr = 32'h80; d_wdata = 32'h5566_7788; d_we = 1'b1; d_req = 1'b1;
        step();
        rst_b = 1'b0; d_req = 1'b0;
        step();
        chk("t5_we", mem_write_en, 1'b0);
        chk("t5_dack", d_ack, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_addr", mem_addr, 32'h0);
        chk("t5_wdata", mem_wdata, 32'h0);
        chk("t5_drdata", d_rdata, 32'h0);
        rst_b = 1'b1;
        step(); step();
        chk("t5_mem_untouched", memarr[8'h20], 32'hC0DE_0020);
        d_we = 1'b0;

        // 6: I drops its request after grant; access still completes
        i_addr = 32'h10; i_req = 1'b1;
        step(); i_req = 1'b0;
        step(); step();
        chk("t6_iack_c3", i_ack, 1'b1);
        chk("t6_rdata", i_rdata, 32'hC0DE_0004);
        step();
        chk("t6_idle_c4", busy, 1'b0);
        d_addr = 32'h104; d_req = 1'b1;
        step();
        chk("t6_dgrant_c5", grant_owner, 1'b1);
        chk("t6_busy_c5", busy, 1'b1);
        step(); step();
        chk("t6_dack_c7", d_ack, 1'b1);
        chk("t6_drdata", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
